// File: rtl/stage_sequencer_pkg.sv
// Shared types and constants for the stage sequencer and its watchdog.
// Holds the mode encoding, the error-cause codes and a stage one-hot helper.
package stage_sequencer_pkg;

  localparam int MAX_STAGES = 16;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_HALTED = 2'd1,
    MODE_ERROR  = 2'd2
  } mode_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_FAULT   = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  function automatic logic [MAX_STAGES-1:0] stage_onehot(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage wait counter; flags expiry in the cycle whose wait would reach the limit.
// With TIMEOUT_CYCLES=0 the watchdog is removed and expired is tied low.
module stage_watchdog
  import stage_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int W = $clog2(TIMEOUT_CYCLES + 1);
      logic [W-1:0] count;

      // Wait counter: cleared on advance/resume, counts idle RUN cycles.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (count_en && (count != W'(TIMEOUT_CYCLES))) begin
          count <= count + W'(1);
        end
      end

      // This idle cycle is the one that takes the count to the limit.
      assign expired = count_en && (count == W'(TIMEOUT_CYCLES - 1));
    end else begin : g_off
      logic unused_wd;
      assign unused_wd = ^{clk, reset_n, clear, count_en};
      assign expired   = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/stage_sequencer.sv
// Walks a one-hot enable through NUM_STAGES stages per instruction, with halt at
// instruction boundaries, fault/timeout capture into ERROR and a retired-instruction count.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_STAGES-1:0]         stage_ready,
  input  logic [NUM_STAGES-1:0]         stage_error,
  input  logic                          halt_req,
  input  logic                          clear_error,
  output logic [NUM_STAGES-1:0]         stage_enable,
  output logic                          halted,
  output logic                          error,
  output logic [$clog2(NUM_STAGES)-1:0] error_stage,
  output logic [1:0]                    error_cause,
  output logic                          retire,
  output logic [COUNT_WIDTH-1:0]        retired_count
);

  localparam int CUR_W = $clog2(NUM_STAGES);

  mode_t            mode;
  logic [CUR_W-1:0] cur;
  logic [CUR_W-1:0] cur_inc;
  logic             cur_ready;
  logic             cur_error;
  logic             in_run;
  logic             is_last;
  logic             fault;
  logic             advance;
  logic             timeout;
  logic             resume;
  logic             wd_clear;
  logic             wd_count_en;

  function automatic logic [NUM_STAGES-1:0] enable_for(input logic [CUR_W-1:0] idx);
    return NUM_STAGES'(stage_onehot(4'(idx)));
  endfunction

  assign cur_ready   = stage_ready[cur];
  assign cur_error   = stage_error[cur];
  assign in_run      = (mode == MODE_RUN);
  assign is_last     = (cur == CUR_W'(NUM_STAGES - 1));
  assign cur_inc     = cur + CUR_W'(1);
  assign fault       = in_run && cur_error;
  assign advance     = in_run && cur_ready && !cur_error;
  assign resume      = ((mode == MODE_HALTED) && !halt_req) ||
                       ((mode == MODE_ERROR) && clear_error);
  assign wd_clear    = advance || resume;
  assign wd_count_en = in_run && !cur_ready && !cur_error;
  // Reset abandons the instruction, so a completing last stage does not retire.
  assign retire      = advance && is_last && reset_n;

  stage_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expired  (timeout)
  );

  // Mode/stage state machine with registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode          <= MODE_RUN;
      cur           <= '0;
      stage_enable  <= NUM_STAGES'(1'b1);
      halted        <= 1'b0;
      error         <= 1'b0;
      error_stage   <= '0;
      error_cause   <= CAUSE_NONE;
      retired_count <= '0;
    end else begin
      case (mode)
        MODE_RUN: begin
          if (fault) begin
            mode         <= MODE_ERROR;
            stage_enable <= '0;
            error        <= 1'b1;
            error_stage  <= cur;
            error_cause  <= CAUSE_FAULT;
          end else if (timeout) begin
            mode         <= MODE_ERROR;
            stage_enable <= '0;
            error        <= 1'b1;
            error_stage  <= cur;
            error_cause  <= CAUSE_TIMEOUT;
          end else if (advance) begin
            if (is_last) begin
              cur           <= '0;
              retired_count <= retired_count + COUNT_WIDTH'(1);
              if (halt_req) begin
                mode         <= MODE_HALTED;
                halted       <= 1'b1;
                stage_enable <= '0;
              end else begin
                stage_enable <= NUM_STAGES'(1'b1);
              end
            end else begin
              cur          <= cur_inc;
              stage_enable <= enable_for(cur_inc);
            end
          end
        end
        MODE_HALTED: begin
          if (!halt_req) begin
            mode         <= MODE_RUN;
            cur          <= '0;
            halted       <= 1'b0;
            stage_enable <= NUM_STAGES'(1'b1);
          end
        end
        MODE_ERROR: begin
          if (clear_error) begin
            mode         <= MODE_RUN;
            cur          <= '0;
            error        <= 1'b0;
            error_cause  <= CAUSE_NONE;
            stage_enable <= NUM_STAGES'(1'b1);
          end
        end
        default: begin
          mode         <= MODE_RUN;
          cur          <= '0;
          halted       <= 1'b0;
          error        <= 1'b0;
          error_cause  <= CAUSE_NONE;
          stage_enable <= NUM_STAGES'(1'b1);
        end
      endcase
    end
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 4, number of sequenced stages (legal 2..16).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, per-stage watchdog limit (0 disables the watchdog).
REQ-003 The block SHALL have parameter COUNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-004 The block SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 The block SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port stage_ready  input  NUM_STAGES  per-stage done strobe.
REQ-007 The block SHALL have port stage_error  input  NUM_STAGES  per-stage fault strobe.
REQ-008 The block SHALL have port halt_req  input  1  level request to stop at the next instruction boundary.
REQ-009 The block SHALL have port clear_error  input  1  pulse that leaves the ERROR state.
REQ-010 The block SHALL have port stage_enable  output  NUM_STAGES  one-hot active-stage enable.
REQ-011 The block SHALL have port halted  output  1  high while in HALTED.
REQ-012 The block SHALL have port error  output  1  high while in ERROR.
REQ-013 The block SHALL have port error_stage  output  $clog2(NUM_STAGES)  index of the faulting stage.
REQ-014 The block SHALL have port error_cause  output  2  0 none, 1 stage fault, 2 timeout.
REQ-015 The block SHALL have port retire  output  1  one-cycle pulse when the last stage completes.
REQ-016 The block SHALL have port retired_count  output  COUNT_WIDTH  count of completed instructions.

Function
REQ-017 The block SHALL implement modes RUN, HALTED and ERROR, plus a stage index cur in 0..NUM_STAGES-1.
REQ-018 In RUN, stage_enable SHALL be one-hot at bit cur; in HALTED and ERROR, stage_enable SHALL be all zero.
REQ-019 Only stage_ready[cur] and stage_error[cur] SHALL be considered; bits of non-enabled stages are ignored.
REQ-020 In RUN, stage_ready[cur] high with stage_error[cur] low SHALL advance cur to cur+1 on the next edge.
REQ-021 Completion of stage NUM_STAGES-1 SHALL wrap cur to 0, pulse retire in the same cycle, and increment retired_count modulo 2^COUNT_WIDTH.
REQ-022 If halt_req is high in the completion cycle of stage NUM_STAGES-1, the next mode SHALL be HALTED, and the retire and count update still occur.
REQ-023 halt_req SHALL have no effect mid-instruction (cur != NUM_STAGES-1, or last stage not completing).
REQ-024 In HALTED, halt_req low SHALL return to RUN with cur=0 on the next edge; the first enable appears one cycle after halt_req falls.
REQ-025 In RUN, stage_error[cur] high SHALL enter ERROR with error_stage=cur and error_cause=1; this takes priority over a simultaneous stage_ready[cur].
REQ-026 A wait counter SHALL clear on every stage advance and on entry to RUN, and increment each RUN cycle without ready or error.
REQ-027 With TIMEOUT_CYCLES>0, the wait counter reaching TIMEOUT_CYCLES with no ready in that cycle SHALL enter ERROR with error_cause=2, error_stage=cur.
REQ-028 A stage_ready[cur] arriving in the cycle the limit is reached SHALL advance normally, with no timeout.
REQ-029 A fault SHALL never increment retired_count or pulse retire, even when it occurs in the last stage.
REQ-030 In ERROR, clear_error SHALL return to RUN with cur=0 and set error_cause=0; error_stage holds its last value.
REQ-031 In ERROR, halt_req SHALL be ignored; clear_error asserted outside ERROR SHALL have no effect.
REQ-032 Enter-ERROR decisions and retire SHALL be combinational from the current cycle's inputs; all mode, index and counter updates SHALL be registered with latency 1.

Reset
REQ-033 On reset_n low at a clock edge, the block SHALL set mode=RUN, cur=0, stage_enable=1, halted=0, error=0, error_stage=0, error_cause=0, retired_count=0, wait counter=0.
REQ-034 Reset mid-instruction or in any mode SHALL abandon the instruction without a retire pulse; reset dominates every other input.

Structure
REQ-035 A shared package SHALL hold the mode enum (RUN/HALTED/ERROR) and the cause constants (NONE=0, FAULT=1, TIMEOUT=2).
REQ-036 The watchdog SHALL be a sub-module, stage_watchdog, with clear, count-enable and expired outputs; it is parametrised by TIMEOUT_CYCLES and constant-0 when TIMEOUT_CYCLES=0.

Verification
REQ-037 Bench SHALL cover, with NUM_STAGES=4: ready held high -> enable sequence 1,2,4,8 repeating, retire every 4th cycle, retired_count=3 after 12 cycles.
REQ-038 Bench SHALL cover: halt_req high during stage 3 completion -> halted=1, enable=0, retired_count incremented; halt_req low -> enable=1 one cycle later.
REQ-039 Bench SHALL cover: stage_error[2] together with stage_ready[2] while cur=2 -> error=1, error_stage=2, cause=1, no retire; clear_error -> enable=1.
REQ-040 Bench SHALL cover, with TIMEOUT_CYCLES=8: stage 1 never ready -> ERROR cause=2 after exactly 8 waiting cycles; a variant with ready on cycle 8 advances with no error.
REQ-041 Bench SHALL cover: stage_error[3] while cur=0 -> ignored; COUNT_WIDTH=4 with 16 retires -> retired_count wraps to 0.
REQ-042 Bench SHALL cover: reset_n low during stage 2 and during ERROR -> all outputs at reset values on the next edge.
